axis_decimator: RTL and testbench

//  Multi-channel, runtime-configurable decimator between the ADC capture front end and the DMA path.

---
 rtl/axis_decim_pkg.sv | 30 +++
 rtl/decim_lane.sv | 53 +++++
 rtl/axis_decimator.sv | 121 ++++++++++++
 tb/tb_axis_decimator.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_decim_pkg.sv
// Shared widths, decimation mode encoding and the saturating shift used by AVERAGE lanes.
// Pure definitions: no latency, no flow control.
package axis_decim_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int NUM_CH     = 2;
    localparam int MAX_RATIO  = 256;
    localparam int RATIO_W    = $clog2(MAX_RATIO + 1);
    localparam int ACC_W      = DATA_WIDTH + $clog2(MAX_RATIO);

    typedef enum logic [1:0] {
        PICK    = 2'd0,
        AVERAGE = 2'd1,
        PEAK    = 2'd2
    } decim_mode_t;

    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    function automatic logic [DATA_WIDTH-1:0] sat_shift(input logic [ACC_W-1:0] acc,
                                                        input logic [3:0]       shift);
        logic [ACC_W-1:0] shifted;
        shifted = acc >> shift;
        if (shifted > SAT_MAX) begin
            return {DATA_WIDTH{1'b1}};
        end else begin
            return shifted[DATA_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/decim_lane.sv
// One channel of the decimator: running sum / peak register plus the group result mux.
// Result is combinational from the current sample; no local backpressure (top decides acceptance).
module decim_lane
    import axis_decim_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  smp_vld,
    input  logic                  first,
    input  decim_mode_t           mode,
    input  logic [3:0]            shift,
    input  logic [DATA_WIDTH-1:0] smp_dat,
    output logic [DATA_WIDTH-1:0] res_dat
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] smp_ext;
    logic [ACC_W-1:0] grp;

    // grp is the group value including the current sample; the first sample of a group reloads.
    always_comb begin
        smp_ext = ACC_W'(smp_dat);
        case (mode)
            AVERAGE: grp = first ? smp_ext : acc_q + smp_ext;
            PEAK:    grp = (first || (smp_ext > acc_q)) ? smp_ext : acc_q;
            default: grp = smp_ext;
        endcase

        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (smp_vld) begin
            acc_d = grp;
        end

        if (mode == AVERAGE) begin
            res_dat = sat_shift(grp, shift);
        end else begin
            res_dat = grp[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/axis_decimator.sv
// Multi-channel PICK/AVERAGE/PEAK decimator feeding an AXI-Stream master; result 1 cycle after last sample.
// Source cannot stall: a result completing while the output is stalled is dropped and overrun is set.
module axis_decimator
    import axis_decim_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [RATIO_W-1:0]           cfg_ratio,
    input  logic [1:0]                   cfg_mode,
    input  logic [3:0]                   cfg_shift,
    input  logic                         cfg_load,
    input  logic                         s_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    output logic [NUM_CH*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         overrun
);

    logic [RATIO_W-1:0]           ratio_q, ratio_d;
    logic [RATIO_W-1:0]           cnt_q, cnt_d;
    decim_mode_t                  mode_q, mode_d;
    logic [3:0]                   shift_q, shift_d;
    logic [NUM_CH*DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                         tvalid_q, tvalid_d;
    logic                         overrun_q, overrun_d;
    logic [NUM_CH*DATA_WIDTH-1:0] res_dat;
    logic                         smp_vld;
    logic                         first;
    logic                         last;
    logic                         complete;
    logic                         accept;

    function automatic logic [RATIO_W-1:0] clamp_ratio(input logic [RATIO_W-1:0] r);
        if (r == '0) begin
            return RATIO_W'(1);
        end else if (r > RATIO_W'(MAX_RATIO)) begin
            return RATIO_W'(MAX_RATIO);
        end else begin
            return r;
        end
    endfunction

    // A sample arriving with cfg_load belongs to no group and is dropped.
    assign smp_vld  = s_valid & ~cfg_load;
    assign first    = (cnt_q == '0);
    assign last     = (cnt_q == ratio_q - RATIO_W'(1));
    assign complete = smp_vld & last;
    assign accept   = complete & (~tvalid_q | m_axis_tready);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        decim_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (cfg_load),
            .smp_vld (smp_vld),
            .first   (first),
            .mode    (mode_q),
            .shift   (shift_q),
            .smp_dat (s_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .res_dat (res_dat[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_comb begin
        ratio_d   = ratio_q;
        mode_d    = mode_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        overrun_d = overrun_q;

        if (cfg_load) begin
            ratio_d   = clamp_ratio(cfg_ratio);
            mode_d    = (cfg_mode == 2'd3) ? PICK : decim_mode_t'(cfg_mode);
            shift_d   = cfg_shift;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (smp_vld) begin
            cnt_d = last ? '0 : cnt_q + RATIO_W'(1);
        end

        // The pending beat survives cfg_load; only a handshake or a newer result replaces it.
        if (accept) begin
            tdata_d  = res_dat;
            tvalid_d = 1'b1;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (complete && tvalid_q && !m_axis_tready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ratio_q   <= RATIO_W'(1);
            mode_q    <= PICK;
            shift_q   <= '0;
            cnt_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ratio_q   <= ratio_d;
            mode_q    <= mode_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_axis_decimator.sv
// Bench for axis_decimator: directed scenarios plus gapped random traffic against a group-queue model.
module tb_axis_decimator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  cfg_ratio;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_shift;
    logic        cfg_load;
    logic        s_valid;
    logic [23:0] s_data;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        overrun;

    int vec  = 0;
    int miss = 0;

    // Reference model state: active config, samples of the open group, output register.
    int          m_n, m_mode, m_shift;
    logic [23:0] grp[$];
    bit          mv, mov;
    logic [23:0] md;

    always #5 clk = ~clk;

    axis_decimator dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_ratio     (cfg_ratio),
        .cfg_mode      (cfg_mode),
        .cfg_shift     (cfg_shift),
        .cfg_load      (cfg_load),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overrun       (overrun)
    );

    function automatic int lane_res(input int ch);
        int s, mx, v;
        s  = 0;
        mx = -1;
        foreach (grp[i]) begin
            v = int'(grp[i][ch*12 +: 12]);
            s += v;
            if (v > mx) mx = v;
        end
        if (m_mode == 1) begin
            s = s >> m_shift;
            return (s > 4095) ? 4095 : s;
        end else if (m_mode == 2) begin
            return mx;
        end
        return int'(grp[grp.size()-1][ch*12 +: 12]);
    endfunction

    task automatic model_update();
        bit hs, took;
        int r, r0, r1;
        if (!reset_n) begin
            m_n = 1; m_mode = 0; m_shift = 0;
            grp.delete();
            mv = 0; mov = 0; md = '0;
            return;
        end
        hs   = mv && m_axis_tready;
        took = 0;
        if (cfg_load) begin
            r       = int'(cfg_ratio);
            m_n     = (r == 0) ? 1 : ((r > 256) ? 256 : r);
            m_mode  = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
            m_shift = int'(cfg_shift);
            grp.delete();
            mov = 0;
        end else if (s_valid) begin
            grp.push_back(s_data);
            if (grp.size() == m_n) begin
                r0 = lane_res(0);
                r1 = lane_res(1);
                grp.delete();
                if (!mv || m_axis_tready) begin
                    md   = {r1[11:0], r0[11:0]};
                    took = 1;
                end else begin
                    mov = 1;
                end
            end
        end
        if (took) mv = 1;
        else if (hs) mv = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic put(input bit v, input int d0, input int d1, input bit rdy);
        s_valid       = v;
        s_data        = {d1[11:0], d0[11:0]};
        m_axis_tready = rdy;
        cyc();
    endtask

    task automatic load(input int r, input int m, input int sh, input bit v);
        cfg_ratio = r[8:0];
        cfg_mode  = m[1:0];
        cfg_shift = sh[3:0];
        cfg_load  = 1'b1;
        s_valid   = v;
        cyc();
        cfg_load  = 1'b0;
        s_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        s_valid = 1'b1;
        s_data  = 24'h5a5a5a;
        m_axis_tready = 1'b0;
        cyc();
        cyc();
        vec++; if (m_axis_tvalid !== 1'b0) begin miss++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        vec++; if (m_axis_tdata !== 24'h0) begin miss++; $display("FAIL reset_tdata: got %h want 000000", m_axis_tdata); end
        vec++; if (overrun !== 1'b0) begin miss++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        reset_n = 1'b1;
        put(1, 'h123, 'h456, 1);
        vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h456123) begin
            miss++; $display("FAIL reset_default_cfg: got v=%b d=%h want v=1 d=456123", m_axis_tvalid, m_axis_tdata);
        end
    endtask

    task automatic test_pick();
        int beats = 0;
        m_axis_tready = 1'b1;
        load(4, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            put(1, i, 200 + i, 1);
            vec++;
            if ({m_axis_tvalid, overrun, m_axis_tdata} !== {mv, mov, md}) begin
                miss++; $display("FAIL pick_model: got v=%b ov=%b d=%h want v=%b ov=%b d=%h",
                                 m_axis_tvalid, overrun, m_axis_tdata, mv, mov, md);
            end
            vec++;
            if (i % 4 == 3) begin
                beats++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata[11:0] !== i[11:0]) begin
                    miss++; $display("FAIL pick_beat: got v=%b ch0=%0d want v=1 ch0=%0d", m_axis_tvalid, m_axis_tdata[11:0], i);
                end
            end else if (m_axis_tvalid !== 1'b0) begin
                miss++; $display("FAIL pick_gap: got tvalid=%b want 0 at sample %0d", m_axis_tvalid, i);
            end
        end
    endtask

    task automatic test_average();
        load(8, 1, 3, 0);
        for (int i = 0; i < 16; i++) begin
            put(1, 100, (i % 2 == 1) ? 4095 : 0, 1);
            vec++;
            if ({m_axis_tvalid, overrun, m_axis_tdata} !== {mv, mov, md}) begin
                miss++; $display("FAIL avg_model: got v=%b ov=%b d=%h want v=%b ov=%b d=%h",
                                 m_axis_tvalid, overrun, m_axis_tdata, mv, mov, md);
            end
            if (i % 8 == 7) begin
                vec++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {12'd2047, 12'd100}) begin
                    miss++; $display("FAIL avg_value: got v=%b d=%h want v=1 d=7ff064", m_axis_tvalid, m_axis_tdata);
                end
            end
        end
    endtask

    task automatic test_saturate_peak();
        int pk[5] = '{3, 9, 9, 2, 1};
        load(256, 1, 0, 0);
        for (int i = 0; i < 256; i++) begin
            put(1, 4095, 4095, 1);
            vec++;
            if ({m_axis_tvalid, overrun, m_axis_tdata} !== {mv, mov, md}) begin
                miss++; $display("FAIL sat_model: got v=%b ov=%b d=%h want v=%b ov=%b d=%h",
                                 m_axis_tvalid, overrun, m_axis_tdata, mv, mov, md);
            end
        end
        vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'hffffff) begin
            miss++; $display("FAIL sat_value: got v=%b d=%h want v=1 d=ffffff", m_axis_tvalid, m_axis_tdata);
        end
        load(5, 2, 0, 0);
        for (int i = 0; i < 5; i++) begin
            put(1, pk[i], int'($urandom_range(0, 4095)), 1);
            vec++;
            if ({m_axis_tvalid, overrun, m_axis_tdata} !== {mv, mov, md}) begin
                miss++; $display("FAIL peak_model: got v=%b ov=%b d=%h want v=%b ov=%b d=%h",
                                 m_axis_tvalid, overrun, m_axis_tdata, mv, mov, md);
            end
        end
        vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata[11:0] !== 12'd9) begin
            miss++; $display("FAIL peak_value: got v=%b ch0=%0d want v=1 ch0=9", m_axis_tvalid, m_axis_tdata[11:0]);
        end
    endtask

    task automatic test_overrun();
        m_axis_tready = 1'b1;
        load(1, 0, 0, 0);
        put(1, 11, 1, 0);
        vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata[11:0] !== 12'd11 || overrun !== 1'b0) begin
            miss++; $display("FAIL ovr_first: got v=%b ch0=%0d ov=%b want v=1 ch0=11 ov=0", m_axis_tvalid, m_axis_tdata[11:0], overrun);
        end
        put(1, 22, 2, 0);
        put(1, 33, 3, 0);
        vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata[11:0] !== 12'd11 || overrun !== 1'b1) begin
            miss++; $display("FAIL ovr_held: got v=%b ch0=%0d ov=%b want v=1 ch0=11 ov=1", m_axis_tvalid, m_axis_tdata[11:0], overrun);
        end
        load(1, 0, 0, 0);
        vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata[11:0] !== 12'd11 || overrun !== 1'b0) begin
            miss++; $display("FAIL ovr_load: got v=%b ch0=%0d ov=%b want v=1 ch0=11 ov=0", m_axis_tvalid, m_axis_tdata[11:0], overrun);
        end
        put(0, 0, 0, 1);
        vec++;
        if (m_axis_tvalid !== 1'b0 || overrun !== 1'b0) begin
            miss++; $display("FAIL ovr_drain: got v=%b ov=%b want v=0 ov=0", m_axis_tvalid, overrun);
        end
    endtask

    task automatic test_load_mid();
        m_axis_tready = 1'b1;
        load(4, 0, 0, 0);
        put(1, 1, 1, 1);
        put(1, 2, 2, 1);
        s_data = 24'h04d04d;
        load(4, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            put(1, 50 + i, 90 + i, 1);
            vec++;
            if ({m_axis_tvalid, overrun, m_axis_tdata} !== {mv, mov, md}) begin
                miss++; $display("FAIL mid_model: got v=%b ov=%b d=%h want v=%b ov=%b d=%h",
                                 m_axis_tvalid, overrun, m_axis_tdata, mv, mov, md);
            end
            vec++;
            if (i < 3 && m_axis_tvalid !== 1'b0) begin
                miss++; $display("FAIL mid_early: got tvalid=%b want 0 after sample %0d", m_axis_tvalid, i);
            end else if (i == 3 && (m_axis_tvalid !== 1'b1 || m_axis_tdata[11:0] !== 12'd53)) begin
                miss++; $display("FAIL mid_result: got v=%b ch0=%0d want v=1 ch0=53", m_axis_tvalid, m_axis_tdata[11:0]);
            end
        end
        load(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            put(1, 60 + i, 70 + i, 1);
            vec++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata[11:0] !== 12'(60 + i)) begin
                miss++; $display("FAIL ratio0: got v=%b ch0=%0d want v=1 ch0=%0d", m_axis_tvalid, m_axis_tdata[11:0], 60 + i);
            end
        end
    endtask

    task automatic test_random();
        int rt[8] = '{0, 1, 2, 3, 5, 7, 16, 300};
        int r, n;
        for (int blk = 0; blk < 10; blk++) begin
            r = rt[$urandom_range(0, 7)];
            n = (r == 0) ? 1 : ((r > 256) ? 256 : r);
            load(r, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
            for (int c = 0; c < n * 5 + 40; c++) begin
                put(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                    $urandom_range(0, 3) != 0);
                vec++;
                if ({m_axis_tvalid, overrun, m_axis_tdata} !== {mv, mov, md}) begin
                    miss++; $display("FAIL rand_model: blk=%0d n=%0d got v=%b ov=%b d=%h want v=%b ov=%b d=%h",
                                     blk, n, m_axis_tvalid, overrun, m_axis_tdata, mv, mov, md);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        m_axis_tready = 1'b0;
        load(2, 2, 0, 0);
        put(1, 5, 5, 0);
        put(1, 6, 6, 0);
        put(1, 9, 9, 0);
        reset_n = 1'b0;
        s_valid = 1'b0;
        cyc();
        reset_n = 1'b1;
        vec++;
        if (m_axis_tvalid !== 1'b0 || overrun !== 1'b0 || m_axis_tdata !== 24'h0) begin
            miss++; $display("FAIL reset_mid: got v=%b ov=%b d=%h want v=0 ov=0 d=000000", m_axis_tvalid, overrun, m_axis_tdata);
        end
        put(1, 7, 8, 1);
        vec++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 24'h008007) begin
            miss++; $display("FAIL reset_mid_cfg: got v=%b d=%h want v=1 d=008007", m_axis_tvalid, m_axis_tdata);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        cfg_ratio     = '0;
        cfg_mode      = '0;
        cfg_shift     = '0;
        cfg_load      = 1'b0;
        s_valid       = 1'b0;
        s_data        = '0;
        m_axis_tready = 1'b0;
        test_reset();
        test_pick();
        test_average();
        test_saturate_peak();
        test_overrun();
        test_load_mid();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
